uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Oversampling UART receiver; successor to the fixed-rate receiver.
//  - Runtime baud divisor, parity and stop-bit configuration.
//  - 3-sample majority vote per bit; glitch-rejecting start detection.
//  - Framing, parity and break detection.
//  - valid/ready output handshake with overrun reporting.
//  - Sits between the pad synchroniser-free rx pin and a bus/CSR interface.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, 5..9, LSB first
//  OSR         16  ticks per bit, even, >=8
//  DIV_W       16  width of cfg_div
//  FIFO_DEPTH  8   output FIFO entries, power of 2 (UART_RX_FIFO_EN only)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          asynchronous active-low reset
//  rx             in   1          serial input, asynchronous, idles high
//  cfg_div        in   DIV_W      tick period = cfg_div+1 clk cycles
//  cfg_parity     in   2          0=none, 1=odd, 2=even, 3=treated as none
//  cfg_stop2      in   1          1 = two stop bits expected
//  rx_data        out  DATA_BITS  received word
//  rx_parity_err  out  1          word flag: parity mismatch
//  rx_frame_err   out  1          word flag: a stop bit sampled 0
//  rx_break       out  1          word flag: data, parity and stop all 0
//  rx_valid       out  1          word + flags available
//  rx_ready       in   1          consumer accepts word when valid&&ready
//  rx_overrun     out  1          1-cycle pulse: completed word dropped
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - All outputs 0; synchroniser flops 1; FSM IDLE.
//    - Tick counter 0; buffered words discarded.
//    - Reset mid-frame abandons the frame silently.
//  - rx passes a 2-flop synchroniser; all logic uses synced value rxs.
//  - Tick generator:
//    - Counter 0..cfg_div; tick on the cycle it equals cfg_div, then wraps to 0.
//    - cfg_div=0: tick every cycle.
//  - Config is captured on start detection; changes mid-frame take effect next frame.
//  - Bit timing:
//    - Sample counter s runs 0..OSR-1 on ticks.
//    - Samples taken at s = OSR/2-1, OSR/2, OSR/2+1; bit = 2-of-3 majority.
//    - Decision made at s = OSR/2+1.
//  - FSM (state advances at s = OSR-1 unless noted):
//    - IDLE: rxs==0 -> START; s and tick counter cleared.
//    - START: majority 1 -> IDLE, glitch rejected with no flags; else -> DATA.
//    - DATA: shift DATA_BITS bits LSB first -> PARITY if enabled, else STOP.
//    - PARITY: err = odd ? (rx == ^data) : (rx == ~^data).
//    - STOP: each stop bit majority 0 sets frame_err.
//      - At the decision point of the last stop bit: push word, -> IDLE immediately (half-bit early, for resync).
//  - Break: all data bits 0, parity bit 0 if enabled, stop 0 => break=1, frame_err=1.
//    - FSM then waits in IDLE for rxs==1 before arming start detection.
//  - Push: word and 3 flags stored together; flags travel with their word.
//  - Handshake:
//    - rx_data/flags stable while rx_valid && !rx_ready.
//    - rx_valid falls the cycle after acceptance unless another word is queued.
//  - Overrun: push into full storage drops the NEW word and pulses rx_overrun.
//    - Pop and push in the same cycle on full storage: both succeed, no overrun.
// CONFIGURATION
//  UART_RX_FIFO_EN
//  - Defined:
//    - FIFO_DEPTH-entry FIFO of {flags, data}, first-word fall-through.
//    - rx_valid = !empty, asserted 1 cycle after push.
//  - Undefined:
//    - Single holding register.
//    - rx_valid asserted the cycle after push.
//    - FIFO_DEPTH ignored.
// STRUCTURE
//  - uart_pkg:
//    - rx state enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT).
//    - Parity constants PAR_NONE/PAR_ODD/PAR_EVEN.
//    - packed struct rx_word_t {break, frame_err, parity_err, data}.
//  - Sub-module uart_sync_fifo (rx_word_t, depth param), instantiated only under UART_RX_FIFO_EN.
// TESTING  (50 MHz clk, 115200 baud, OSR=16 => cfg_div=26)
//  - 8N1 0xA5, rx_ready=1:
//    - rx_valid pulses once, rx_data=0xA5, all flags 0.
//    - Back-to-back 0x00,0xFF -> both received in order.
//  - cfg_parity=2, 0x3C, parity bit 1:
//    - rx_parity_err=1, data 0x3C.
//    - Same with parity bit 0 -> err 0.
//    - cfg_parity=1 mirror case.
//  - 0x55 with stop bit 0:
//    - frame_err=1, break=0.
//    - cfg_stop2=1 with second stop 0 -> frame_err=1.
//  - Glitches:
//    - rx low for 4 ticks -> no rx_valid, FSM back in IDLE.
//    - Single-tick glitch mid data bit -> majority still correct.
//  - rx low 12 bit times, then high:
//    - One word, data=0, break=1, frame_err=1.
//    - No further word until rx has gone high.
//  - rx_ready=0, send 2 words (no macro) or FIFO_DEPTH+1 words (macro):
//    - Last word dropped with one rx_overrun pulse; earlier words intact in order.
//    - rst_n low mid-frame -> outputs 0, next frame received clean.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, parity codes
// and the word record that carries data together with its status flags.
package uart_pkg;

    localparam int WORD_DATA_W = 9;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // Data is sized for the widest supported frame; narrower frames zero-extend.
    typedef struct packed {
        logic                   brk;
        logic                   frame_err;
        logic                   parity_err;
        logic [WORD_DATA_W-1:0] data;
    } rx_word_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO of received words; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  rx_word_t wdata,
    output rx_word_t rdata,
    output logic     empty,
    output logic     full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rx_word_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, parity/framing/break
// flags and a valid/ready output; UART_RX_FIFO_EN selects a FIFO over one register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OSR        = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output rx_state_t            rx_state
);

    localparam int S_W  = $clog2(OSR);
    localparam int BI_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0]  S_A     = S_W'(OSR/2 - 1);
    localparam logic [S_W-1:0]  S_B     = S_W'(OSR/2);
    localparam logic [S_W-1:0]  S_C     = S_W'(OSR/2 + 1);
    localparam logic [S_W-1:0]  S_LAST  = S_W'(OSR - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rxs;
    rx_state_t            state;
    logic [DIV_W-1:0]     tick_cnt;
    logic [DIV_W-1:0]     div_q;
    logic [1:0]           parity_q;
    logic                 stop2_q;
    logic [S_W-1:0]       s_cnt;
    logic [1:0]           samp;
    logic                 bit_q;
    logic [DATA_BITS-1:0] shreg;
    logic [BI_W-1:0]      bit_idx;
    logic                 stop_idx;
    logic                 par_err_q;
    logic                 frame_err_q;
    logic                 all_zero;
    logic                 push_q;
    rx_word_t             word_new;

    logic tick;
    logic dec;
    logic adv;
    logic maj;
    logic par_en;
    logic brk_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Ticks only run while a frame is in progress; idle holds the divider at 0.
    assign tick    = (state != IDLE) && (state != BRK_WAIT) && (tick_cnt == div_q);
    assign dec     = tick && (s_cnt == S_C);
    assign adv     = tick && (s_cnt == S_LAST);
    assign maj     = maj3(samp[0], samp[1], rxs);
    assign par_en  = (parity_q == PAR_ODD) || (parity_q == PAR_EVEN);
    assign brk_now = all_zero && !maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            div_q       <= '0;
            parity_q    <= PAR_NONE;
            stop2_q     <= 1'b0;
            s_cnt       <= '0;
            samp        <= 2'b11;
            bit_q       <= 1'b1;
            shreg       <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            all_zero    <= 1'b0;
            push_q      <= 1'b0;
            word_new    <= '0;
        end else begin
            push_q <= 1'b0;

            if (state == IDLE || state == BRK_WAIT || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + DIV_W'(1);
            end

            if (tick) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + S_W'(1);
                if (s_cnt == S_A) samp[0] <= rxs;
                if (s_cnt == S_B) samp[1] <= rxs;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state       <= START;
                        s_cnt       <= '0;
                        div_q       <= cfg_div;
                        parity_q    <= cfg_parity;
                        stop2_q     <= cfg_stop2;
                        bit_idx     <= '0;
                        stop_idx    <= 1'b0;
                        par_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        all_zero    <= 1'b1;
                    end
                end
                START: begin
                    if (dec) bit_q <= maj;
                    if (adv) state <= bit_q ? IDLE : DATA;
                end
                DATA: begin
                    if (dec) begin
                        shreg    <= {maj, shreg[DATA_BITS-1:1]};
                        all_zero <= all_zero & ~maj;
                    end
                    if (adv) begin
                        if (bit_idx == BI_LAST) begin
                            state <= par_en ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + BI_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (dec) begin
                        par_err_q <= (parity_q == PAR_ODD) ? (maj == ^shreg) : (maj == ~^shreg);
                        all_zero  <= all_zero & ~maj;
                    end
                    if (adv) state <= STOP;
                end
                STOP: begin
                    // The last stop bit ends the frame at its centre so the next start edge is not missed.
                    if (dec) begin
                        if (stop_idx == stop2_q) begin
                            push_q              <= 1'b1;
                            word_new.brk        <= brk_now;
                            word_new.frame_err  <= frame_err_q | ~maj;
                            word_new.parity_err <= par_err_q;
                            word_new.data       <= WORD_DATA_W'(shreg);
                            state               <= brk_now ? BRK_WAIT : IDLE;
                        end else begin
                            frame_err_q <= frame_err_q | ~maj;
                            all_zero    <= all_zero & ~maj;
                        end
                    end
                    if (adv) stop_idx <= 1'b1;
                end
                BRK_WAIT: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake: a word transfers on any cycle with rx_valid && rx_ready; while
    // rx_valid is high and rx_ready low, rx_data and the flags hold steady.
    rx_word_t out_word;
    logic     out_valid;
    logic     ovr_q;

`ifdef UART_RX_FIFO_EN
    rx_word_t fifo_q;
    logic     fifo_empty;
    logic     fifo_full;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (rx_ready && !fifo_empty),
        .wdata (word_new),
        .rdata (fifo_q),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign out_valid = !fifo_empty;
    assign out_word  = out_valid ? fifo_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= push_q && fifo_full && !rx_ready;
        end
    end
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    rx_word_t hold_q;
    logic     hold_v;
    logic     pop;

    assign pop       = hold_v && rx_ready;
    assign out_valid = hold_v;
    assign out_word  = hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            hold_v <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= push_q && hold_v && !pop;
            if (push_q && (!hold_v || pop)) begin
                hold_q <= word_new;
                hold_v <= 1'b1;
            end else if (pop) begin
                hold_v <= 1'b0;
            end
        end
    end
`endif

    rx_word_t unused_word;
    assign unused_word = out_word;

    assign rx_data       = out_word.data[DATA_BITS-1:0];
    assign rx_parity_err = out_word.parity_err;
    assign rx_frame_err  = out_word.frame_err;
    assign rx_break      = out_word.brk;
    assign rx_valid      = out_valid;
    assign rx_overrun    = ovr_q;
    assign rx_state      = state;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: drives serial frames and compares received
// words {brk, frame_err, parity_err, 0, data} against hand-computed values.
module tb_uart_rx_os;
    import uart_pkg::*;

`ifdef UART_RX_FIFO_EN
    localparam int N_HOLD = 8;
`else
    localparam int N_HOLD = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic [7:0]  rx_data;
    logic        rx_parity_err;
    logic        rx_frame_err;
    logic        rx_break;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_overrun;
    rx_state_t   rx_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ovr_cnt = 0;
    int          bit_clks = 64;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];

    uart_rx_os dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .cfg_div       (cfg_div),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_break      (rx_break),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_overrun    (rx_overrun),
        .rx_state      (rx_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // output monitor
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready)
            got_q.push_back({rx_break, rx_frame_err, rx_parity_err, 1'b0, rx_data});
        if (rst_n && rx_overrun)
            ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clks(bit_clks);
    endtask

    // gbit selects a data bit that gets a one-tick inverted glitch at its centre
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pbit,
                              input logic stop_a, input logic stop_b, input int gbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                rx = d[i];
                wait_clks(bit_clks/2 - 2);
                rx = ~d[i];
                wait_clks(4);
                rx = d[i];
                wait_clks(bit_clks/2 - 2);
            end else begin
                drive_bit(d[i]);
            end
        end
        if (par_en) drive_bit(pbit);
        drive_bit(stop_a);
        if (cfg_stop2) drive_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        logic [11:0] e;
        logic [11:0] g;
        wait_clks(8);
        check({tag, " count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front();
            else g = 12'hxxx;
            check({tag, " word"}, g, e);
        end
        got_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        rx         = 1'b1;
        rx_ready   = 1'b1;
        cfg_div    = 16'd3;
        cfg_parity = PAR_NONE;
        cfg_stop2  = 1'b0;
        wait_clks(5);
        check("rst valid", rx_valid, 0);
        check("rst data", rx_data, 0);
        check("rst flags", {rx_break, rx_frame_err, rx_parity_err}, 0);
        check("rst overrun", rx_overrun, 0);
        check("rst state", rx_state, IDLE);
        rst_n = 1'b1;
        wait_clks(10);

        send_frame(8'hA5, 0, 0, 1, 1, -1); exp_q.push_back(12'h0A5);
        wait_clks(bit_clks);
        drain("8n1 a5");

        send_frame(8'h00, 0, 0, 1, 1, -1); exp_q.push_back(12'h000);
        send_frame(8'hFF, 0, 0, 1, 1, -1); exp_q.push_back(12'h0FF);
        wait_clks(bit_clks);
        drain("b2b");

        cfg_parity = PAR_EVEN;
        send_frame(8'h3C, 1, 1, 1, 1, -1); exp_q.push_back(12'h23C);
        send_frame(8'h3C, 1, 0, 1, 1, -1); exp_q.push_back(12'h03C);
        send_frame(8'h07, 1, 0, 1, 1, -1); exp_q.push_back(12'h207);
        wait_clks(bit_clks);
        drain("even");

        cfg_parity = PAR_ODD;
        send_frame(8'h3C, 1, 1, 1, 1, -1); exp_q.push_back(12'h03C);
        send_frame(8'h3C, 1, 0, 1, 1, -1); exp_q.push_back(12'h23C);
        wait_clks(bit_clks);
        drain("odd");
        cfg_parity = PAR_NONE;

        send_frame(8'h55, 0, 0, 0, 1, -1); exp_q.push_back(12'h455);
        wait_clks(bit_clks);
        drain("stop0");

        cfg_stop2 = 1'b1;
        send_frame(8'h55, 0, 0, 1, 0, -1); exp_q.push_back(12'h455);
        send_frame(8'hC3, 0, 0, 1, 1, -1); exp_q.push_back(12'h0C3);
        wait_clks(bit_clks);
        drain("stop2");
        cfg_stop2 = 1'b0;

        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(3 * bit_clks);
        check("glitch state", rx_state, IDLE);
        drain("start glitch");

        send_frame(8'hFF, 0, 0, 1, 1, 3); exp_q.push_back(12'h0FF);
        send_frame(8'h00, 0, 0, 1, 1, 5); exp_q.push_back(12'h000);
        wait_clks(bit_clks);
        drain("bit glitch");

        rx = 1'b0;
        wait_clks(12 * bit_clks);
        check("break count", got_q.size(), 1);
        check("break state", rx_state, BRK_WAIT);
        rx = 1'b1;
        wait_clks(2 * bit_clks);
        check("break idle", rx_state, IDLE);
        exp_q.push_back(12'hC00);
        drain("break");

        cfg_div  = 16'd0;
        bit_clks = 16;
        send_frame(8'h96, 0, 0, 1, 1, -1); exp_q.push_back(12'h096);
        wait_clks(bit_clks);
        drain("div0");
        cfg_div  = 16'd3;
        bit_clks = 64;

        check("no overrun yet", ovr_cnt, 0);
        set_ready(1'b0);
        for (int i = 0; i <= N_HOLD; i++) begin
            send_frame(8'(8'h11 * (i + 1)), 0, 0, 1, 1, -1);
            if (i < N_HOLD) exp_q.push_back({4'h0, 8'(8'h11 * (i + 1))});
        end
        wait_clks(bit_clks);
        check("overrun pulses", ovr_cnt, 1);
        check("overrun valid", rx_valid, 1);
        check("overrun head", rx_data, 8'h11);
        set_ready(1'b1);
        wait_clks(4 * N_HOLD);
        drain("overrun");

        rx = 1'b0;
        wait_clks(bit_clks + bit_clks / 2);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(3);
        check("midrst valid", rx_valid, 0);
        check("midrst data", rx_data, 0);
        check("midrst state", rx_state, IDLE);
        rst_n = 1'b1;
        wait_clks(2 * bit_clks);
        send_frame(8'h5A, 0, 0, 1, 1, -1); exp_q.push_back(12'h05A);
        wait_clks(bit_clks);
        drain("after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
